// File: rtl/mem_copy_dma_pkg.sv
// mem_copy_dma_pkg: shared state encoding and default widths for the copy engine.
package mem_copy_dma_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-at-a-time memory copy with overlapped read/write pipeline.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [15:0]       length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_strobe
);
    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_next;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_addr <= '0;
            r_wr_next <= '0;
            r_wr_addr <= '0;
            r_wr_en   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && length != 16'd0) begin
                        r_state   <= RUN;
                        r_cnt     <= length;
                        r_rd_addr <= src_addr;
                        r_wr_next <= dst_addr;
                    end else if (start) begin
                        r_state <= DONE;
                    end
                end
                RUN: begin
                    // each read issued here is written back on the following cycle
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_wr_next;
                    r_wr_next <= r_wr_next + ADDR_W'(1);
                    r_cnt     <= r_cnt - 16'd1;
                    if (abort || r_cnt == 16'd1) begin
                        r_state   <= DRAIN;
                        r_rd_addr <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    r_state   <= DONE;
                    r_wr_en   <= 1'b0;
                    r_wr_addr <= '0;
                    r_wr_next <= '0;
                    r_cnt     <= '0;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = (r_state == RUN) || (r_state == DRAIN);
    assign done         = (r_state == DONE);
    assign read_addr    = r_rd_addr;
    assign write_addr   = r_wr_addr;
    assign write_strobe = r_wr_en;
    assign write_data   = r_wr_en ? read_data : '0;
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: randomized self-checking bench with a RAM responder and copy reference model.
module tb_mem_copy_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] length = '0;
    logic [15:0] read_data = '0;
    logic        busy, done, write_strobe;
    logic [15:0] read_addr, write_addr, write_data;

    int tot = 0;
    int bad = 0;

    logic [15:0] mem [0:65535];
    int unsigned wg  [0:65535];
    int unsigned gen = 32'h5a5a_0001;
    logic [15:0] seed = 16'h1234;

    mem_copy_dma dut (
        .i_clk(clk), .i_rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .read_addr(read_addr), .read_data(read_data),
        .write_addr(write_addr), .write_data(write_data), .write_strobe(write_strobe)
    );

    always #5 clk = ~clk;

    // RAM view: words not yet written in this generation read as a seeded pattern
    function automatic logic [15:0] ram(input logic [15:0] a);
        return (wg[a] == gen) ? mem[a] : ((a * 16'h9E37) ^ seed);
    endfunction

    always @(posedge clk) begin
        read_data <= ram(read_addr);
        if (write_strobe) begin
            mem[write_addr] <= write_data;
            wg[write_addr]  <= gen;
        end
    end

    task automatic new_mem();
        gen  = gen + 1;
        seed = 16'($urandom);
    endtask

    task automatic test_copy(input string nm, input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] l, input int ab, input bit rs);
        int n, c, nb, dc, dn, bi, edc;
        logic [15:0] ea[$], ed[$], rq[$], oa[$], od[$];
        int oc[$];
        n = (ab >= 0 && ab + 1 < int'(l)) ? ab + 1 : int'(l);
        for (int k = 0; k < n; k++) begin
            ea.push_back(d + 16'(k));
            ed.push_back(ram(s + 16'(k)));
        end
        nb = 0; dc = -1; dn = 0; bi = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        @(negedge clk);
        start = 1'b0; src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 16'($urandom);
        c = 0;
        while (c < int'(l) + 20 && !(dc >= 0 && c > dc + 1)) begin
            abort = (c == ab);
            start = rs && (c == 1);
            if (busy) begin
                nb++;
                if (c < n) rq.push_back(read_addr);
            end
            if (write_strobe) begin
                oc.push_back(c); oa.push_back(write_addr); od.push_back(write_data);
            end
            if (done) begin
                dn++;
                if (dc < 0) dc = c;
                if (busy || write_strobe || read_addr != 0 || write_addr != 0 || write_data != 0) bi++;
            end
            @(negedge clk);
            c++;
        end
        abort = 1'b0; start = 1'b0;
        edc = (n == 0) ? 0 : n + 1;
        tot++; if (dc !== edc) begin bad++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, dc, edc); end
        tot++; if (dn !== 1) begin bad++; $display("FAIL %s done_pulses got=%0d want=1", nm, dn); end
        tot++; if (nb !== edc) begin bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", nm, nb, edc); end
        tot++; if (oa.size() !== n) begin bad++; $display("FAIL %s strobes got=%0d want=%0d", nm, oa.size(), n); end
        tot++; if (rq.size() !== n) begin bad++; $display("FAIL %s reads got=%0d want=%0d", nm, rq.size(), n); end
        tot++; if (bi !== 0) begin bad++; $display("FAIL %s done_outputs got=%0d want=0", nm, bi); end
        for (int k = 0; k < n && k < oa.size(); k++) begin
            tot++;
            if (oa[k] !== ea[k] || od[k] !== ed[k] || oc[k] !== k + 1) begin
                bad++;
                $display("FAIL %s write[%0d] got=%h/%h@%0d want=%h/%h@%0d", nm, k, oa[k], od[k], oc[k], ea[k], ed[k], k + 1);
            end
        end
        for (int k = 0; k < n && k < rq.size(); k++) begin
            tot++;
            if (rq[k] !== s + 16'(k)) begin
                bad++; $display("FAIL %s read[%0d] got=%h want=%h", nm, k, rq[k], s + 16'(k));
            end
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        tot++; if ({busy, done, write_strobe} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, write_strobe}); end
        tot++; if ({read_addr, write_addr, write_data} !== 48'h0) begin bad++; $display("FAIL reset_bus got=%h want=0", {read_addr, write_addr, write_data}); end
        repeat (2) @(negedge clk);
        tot++; if ({busy, done, write_strobe} !== 3'b000) begin bad++; $display("FAIL reset_hold got=%b want=000", {busy, done, write_strobe}); end
        new_mem();
        rst_n = 1'b1; start = 1'b1; src_addr = 16'h0040; dst_addr = 16'h0080; length = 16'd1;
        @(negedge clk);
        start = 1'b0;
        tot++; if (busy !== 1'b1) begin bad++; $display("FAIL first_edge_start got=%b want=1", busy); end
        repeat (3) @(negedge clk);
        tot++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL first_copy_idle got=%b want=00", {busy, done}); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        new_mem();
        @(negedge clk);
        start = 1'b1; src_addr = 16'h0300; dst_addr = 16'h0400; length = 16'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        tot++; if (write_strobe !== 1'b1) begin bad++; $display("FAIL mid_second_write got=%b want=1", write_strobe); end
        #2 rst_n = 1'b0;
        #1;
        tot++; if ({busy, done, write_strobe} !== 3'b000) begin bad++; $display("FAIL mid_reset_flags got=%b want=000", {busy, done, write_strobe}); end
        tot++; if ({read_addr, write_addr} !== 32'h0) begin bad++; $display("FAIL mid_reset_addr got=%h want=0", {read_addr, write_addr}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (write_strobe || done || busy) cnt++;
        end
        tot++; if (cnt !== 0) begin bad++; $display("FAIL mid_reset_quiet got=%0d want=0", cnt); end
        test_copy("after_reset", 16'h0500, 16'h0600, 16'd2, -1, 1'b0);
    endtask

    task automatic test_basic();
        new_mem();
        test_copy("basic", 16'h0010, 16'h0100, 16'd4, -1, 1'b0);
    endtask

    task automatic test_zero();
        test_copy("zero_len", 16'h0010, 16'h0100, 16'd0, -1, 1'b0);
    endtask

    task automatic test_wrap();
        new_mem();
        test_copy("wrap_src", 16'hFFFE, 16'h0200, 16'd4, -1, 1'b0);
        test_copy("wrap_dst", 16'h2000, 16'hFFFD, 16'd5, -1, 1'b0);
        test_copy("long_wrap", 16'hFF80, 16'h4000, 16'd300, -1, 1'b0);
    endtask

    task automatic test_abort();
        new_mem();
        test_copy("abort_run3", 16'h0700, 16'h0800, 16'd8, 2, 1'b0);
        test_copy("abort_first", 16'h0900, 16'h0A00, 16'd5, 0, 1'b0);
        test_copy("abort_drain", 16'h0B00, 16'h0C00, 16'd5, 5, 1'b0);
    endtask

    task automatic test_restart();
        new_mem();
        test_copy("restart_ignored", 16'h0D00, 16'h0E00, 16'd6, -1, 1'b1);
    endtask

    task automatic test_overlap();
        new_mem();
        test_copy("overlap_lower", 16'h1000, 16'h0FFD, 16'd10, -1, 1'b0);
        test_copy("overlap_same", 16'h1100, 16'h1100, 16'd7, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] s, d, l;
        int ab;
        for (int i = 0; i < 8; i++) begin
            new_mem();
            s = 16'($urandom);
            l = 16'($urandom_range(1, 40));
            d = ($urandom_range(0, 1) == 1) ? s + 16'h8000 : s - 16'($urandom_range(0, 50));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : -1;
            test_copy("random", s, d, l, ab, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_abort();
        test_restart();
        test_overlap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
